// File: rtl/wu_trial_scheduler.sv
// Wake-up receiver trial scheduler: optional scan-chain load, periodic triggers, windowed TP/FP/missed scoring.
// Wake edges count 3 cycles after the pin moves; no backpressure. `define WU_LAT_STATS_EN adds min/max/sum latency.
module wu_trial_scheduler #(
   parameter int CNT_W  = 20,
   parameter int TIME_W = 32,
   parameter int TRIG_W = 4
) (
   input  logic                     clki,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     cfg_scan,
   input  logic [CNT_W-1:0]         num_trials,
   input  logic [TIME_W-1:0]        trig_period,
   input  logic [TIME_W-1:0]        win_open,
   input  logic [TIME_W-1:0]        win_close,
   input  logic                     sc_done,
   input  logic                     wake_up,
   output logic                     sc_req,
   output logic                     trig_to_siggen,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         trial_idx,
   output logic [CNT_W-1:0]         tp_cnt,
   output logic [CNT_W-1:0]         fp_cnt,
   output logic [CNT_W-1:0]         missed_cnt,
`ifdef WU_LAT_STATS_EN
   output logic [TIME_W-1:0]        min_latency,
   output logic [TIME_W-1:0]        max_latency,
   output logic [TIME_W+CNT_W-1:0]  lat_sum,
`endif
   output logic [TIME_W-1:0]        last_latency
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_ARM,
      S_TRIG,
      S_LISTEN,
      S_DONE
   } state_t;

   localparam logic [TIME_W-1:0] MIN_PERIOD = TIME_W'(TRIG_W + 1);
   localparam logic [TIME_W-1:0] TRIG_LAST  = TIME_W'(TRIG_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   state_t            state;
   logic              wake_s1, wake_s2, wake_s3, wake_edge;
   logic              start_s1, start_s2, scd_s1, scd_s2;
   logic              start_edge, sc_edge;
   logic [CNT_W-1:0]  num_l;
   logic [TIME_W-1:0] period_m1, open_l, close_l, timer;
   logic [TIME_W-1:0] period_eff, close_eff;
   logic              tp_seen;
   logic              in_trial, hit_tp, hit_fp, finalise;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clki or posedge reset) begin
      if (reset) begin
         wake_s1   <= 1'b0;
         wake_s2   <= 1'b0;
         wake_s3   <= 1'b0;
         wake_edge <= 1'b0;
         start_s1  <= 1'b0;
         start_s2  <= 1'b0;
         scd_s1    <= 1'b0;
         scd_s2    <= 1'b0;
      end else begin
         wake_s1   <= wake_up;
         wake_s2   <= wake_s1;
         wake_s3   <= wake_s2;
         wake_edge <= wake_s2 & ~wake_s3;
         start_s1  <= start;
         start_s2  <= start_s1;
         scd_s1    <= sc_done;
         scd_s2    <= scd_s1;
      end
   end

   assign start_edge = start_s1 & ~start_s2;
   assign sc_edge    = scd_s1 & ~scd_s2;

   // Short periods are stretched so every trial has at least one listen cycle after the pulse.
   assign period_eff = (trig_period < MIN_PERIOD) ? MIN_PERIOD : trig_period;
   assign close_eff  = (win_close < trig_period) ? win_close : trig_period;

   assign in_trial = (state == S_TRIG) || (state == S_LISTEN);
   assign hit_tp   = in_trial && wake_edge && !tp_seen && (timer >= open_l) && (timer < close_l);
   assign hit_fp   = in_trial && wake_edge && !hit_tp;
   assign finalise = (state == S_LISTEN) && (timer == period_m1);

   always_ff @(posedge clki or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         sc_req         <= 1'b0;
         trig_to_siggen <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         trial_idx      <= '0;
         tp_cnt         <= '0;
         fp_cnt         <= '0;
         missed_cnt     <= '0;
         last_latency   <= '0;
         num_l          <= '0;
         period_m1      <= '0;
         open_l         <= '0;
         close_l        <= '0;
         timer          <= '0;
         tp_seen        <= 1'b0;
`ifdef WU_LAT_STATS_EN
         min_latency    <= '0;
         max_latency    <= '0;
         lat_sum        <= '0;
`endif
      end else begin
         if (hit_tp) begin
            tp_cnt       <= sat_inc(tp_cnt);
            last_latency <= timer;
            tp_seen      <= 1'b1;
`ifdef WU_LAT_STATS_EN
            if (timer < min_latency) min_latency <= timer;
            if (timer > max_latency) max_latency <= timer;
            lat_sum <= lat_sum + {{CNT_W{1'b0}}, timer};
`endif
         end
         if (hit_fp) fp_cnt <= sat_inc(fp_cnt);

         case (state)
            S_IDLE, S_DONE: begin
               if (start_edge) begin
                  num_l        <= num_trials;
                  period_m1    <= period_eff - 1'b1;
                  open_l       <= win_open;
                  close_l      <= close_eff;
                  trial_idx    <= '0;
                  tp_cnt       <= '0;
                  fp_cnt       <= '0;
                  missed_cnt   <= '0;
                  last_latency <= '0;
`ifdef WU_LAT_STATS_EN
                  min_latency  <= '1;
                  max_latency  <= '0;
                  lat_sum      <= '0;
`endif
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  sc_req       <= cfg_scan;
                  state        <= cfg_scan ? S_SCAN : S_ARM;
               end
            end
            S_SCAN: begin
               if (sc_edge) begin
                  sc_req <= 1'b0;
                  state  <= S_ARM;
               end
            end
            S_TRIG: begin
               timer <= timer + 1'b1;
               if (timer == TRIG_LAST) begin
                  trig_to_siggen <= 1'b0;
                  state          <= S_LISTEN;
               end
            end
            S_ARM, S_LISTEN: begin
               if (state == S_LISTEN && !finalise) begin
                  timer <= timer + 1'b1;
               end else begin
                  // A TP landing on the finalising cycle already counts for this trial.
                  if (state == S_LISTEN && !tp_seen && !hit_tp)
                     missed_cnt <= sat_inc(missed_cnt);
                  if (trial_idx == num_l) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state          <= S_TRIG;
                     trig_to_siggen <= 1'b1;
                     timer          <= '0;
                     tp_seen        <= 1'b0;
                     trial_idx      <= trial_idx + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wu_trial_scheduler.sv
// Directed and randomized campaigns scored against an event-level model of the trial rules.
module tb_wu_trial_scheduler;
   localparam int CNT_W   = 20;
   localparam int TIME_W  = 32;
   localparam int TRIG_W  = 4;
   localparam int PLAN_SZ = 16384;

   logic clki = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic cfg_scan = 1'b0;
   logic sc_done = 1'b0;
   logic wake_up = 1'b0;
   logic [CNT_W-1:0]  num_trials = '0;
   logic [TIME_W-1:0] trig_period = '0;
   logic [TIME_W-1:0] win_open = '0;
   logic [TIME_W-1:0] win_close = '0;
   logic              sc_req, trig_to_siggen, busy, done;
   logic [CNT_W-1:0]  trial_idx, tp_cnt, fp_cnt, missed_cnt;
   logic [TIME_W-1:0] last_latency;

   wu_trial_scheduler #(.CNT_W(CNT_W), .TIME_W(TIME_W), .TRIG_W(TRIG_W)) dut (
      .clki(clki), .reset(reset), .start(start), .cfg_scan(cfg_scan),
      .num_trials(num_trials), .trig_period(trig_period), .win_open(win_open),
      .win_close(win_close), .sc_done(sc_done), .wake_up(wake_up),
      .sc_req(sc_req), .trig_to_siggen(trig_to_siggen), .busy(busy), .done(done),
      .trial_idx(trial_idx), .tp_cnt(tp_cnt), .fp_cnt(fp_cnt), .missed_cnt(missed_cnt),
      .last_latency(last_latency)
   );

   always #5 clki = ~clki;

   int cyc = 0;
   always @(posedge clki) cyc <= cyc + 1;

   // wake_plan[c] = pin level during cycle c
   bit wake_plan [PLAN_SZ];
   always @(posedge clki) begin
      #1;
      wake_up = (cyc < PLAN_SZ) ? wake_plan[cyc] : 1'b0;
   end

   int trig_rise_q[$];
   int trig_w_q[$];
   bit trig_prev = 1'b0;
   int trig_w = 0;
   always @(negedge clki) begin
      if (trig_to_siggen && !trig_prev) trig_rise_q.push_back(cyc);
      if (trig_to_siggen) trig_w = trig_w + 1;
      else if (trig_prev) begin
         trig_w_q.push_back(trig_w);
         trig_w = 0;
      end
      trig_prev = trig_to_siggen;
   end

   int n_vec = 0;
   int n_err = 0;
   int rel_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clki);
         #1;
      end
   endtask

   task automatic sample(input int c);
      goto(c);
      if (clki) @(negedge clki);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_sc_req"}, sc_req, 0);
      chk({tag, "_trig"}, trig_to_siggen, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_trial_idx"}, trial_idx, 0);
      chk({tag, "_tp"}, tp_cnt, 0);
      chk({tag, "_fp"}, fp_cnt, 0);
      chk({tag, "_missed"}, missed_cnt, 0);
      chk({tag, "_last_lat"}, last_latency, 0);
   endtask

   // Runs one campaign with wake pulses at rel_q offsets (pin rise, relative to first trigger).
   task automatic campaign(input string tag, input bit scan, input int n, input int p,
                           input int wo, input int wc, input int scan_wait, input bit poke);
      int s, d, t0, peff, e, close, tp, fp, last, seen, k, t, c, base, wbase;
      int abs_q[$];
      bit got[];
      goto(cyc + 1);
      s     = cyc;
      base  = trig_rise_q.size();
      wbase = trig_w_q.size();
      peff  = (p < TRIG_W + 1) ? TRIG_W + 1 : p;
      d     = s + 2 + scan_wait;
      t0    = scan ? d + 3 : s + 3;
      e     = t0 + n * peff;
      cfg_scan    = scan;
      num_trials  = CNT_W'(n);
      trig_period = TIME_W'(p);
      win_open    = TIME_W'(wo);
      win_close   = TIME_W'(wc);
      start       = 1'b1;
      foreach (rel_q[i]) begin
         c = t0 + rel_q[i];
         abs_q.push_back(c);
         for (int j = 0; j < 3; j++) if (c + j < PLAN_SZ) wake_plan[c + j] = 1'b1;
      end
      abs_q.sort();

      close = (wc < p) ? wc : p;
      got = new[(n > 0) ? n : 1];
      tp = 0; fp = 0; last = 0;
      foreach (abs_q[i]) begin
         seen = abs_q[i] + 3;
         if (seen < t0 || seen >= e) continue;
         k = (seen - t0) / peff;
         t = seen - t0 - k * peff;
         if (t >= wo && t < close && !got[k]) begin
            tp++;
            last = t;
            got[k] = 1'b1;
         end else fp++;
      end

      sample(s + 1);
      chk({tag, "_busy_pre"}, busy, 0);
      sample(s + 2);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_clr"}, done, 0);
      chk({tag, "_sc_req_on"}, sc_req, scan);
      goto(s + 3);
      start = 1'b0;
      if (poke) begin
         goto(s + 8);
         start = 1'b1;
         goto(s + 12);
         start = 1'b0;
      end
      if (scan) begin
         sample(s + 2 + scan_wait / 2);
         chk({tag, "_sc_req_hold"}, sc_req, 1);
         goto(d);
         sc_done = 1'b1;
         sample(d + 1);
         chk({tag, "_sc_req_last"}, sc_req, 1);
         sample(d + 2);
         chk({tag, "_sc_req_drop"}, sc_req, 0);
      end
      if (n > 0) begin
         sample(e - 1);
         chk({tag, "_done_early"}, done, 0);
      end
      sample(e);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      sample(e + 20);
      chk({tag, "_trial_idx"}, trial_idx, n);
      chk({tag, "_tp"}, tp_cnt, tp);
      chk({tag, "_fp"}, fp_cnt, fp);
      chk({tag, "_missed"}, missed_cnt, n - tp);
      chk({tag, "_last_lat"}, last_latency, last);
      chk({tag, "_sc_req_end"}, sc_req, 0);
      chk({tag, "_n_trig"}, trig_rise_q.size() - base, n);
      for (int i = 0; i < n && base + i < trig_rise_q.size(); i++)
         chk($sformatf("%s_trig%0d_at", tag, i), trig_rise_q[base + i], t0 + i * peff);
      for (int i = 0; i < n && wbase + i < trig_w_q.size(); i++)
         chk($sformatf("%s_trig%0d_w", tag, i), trig_w_q[wbase + i], TRIG_W);
      sc_done = 1'b0;
      rel_q.delete();
   endtask

   initial begin
      int s, n, p, wo, wc, cur;
      #1 reset = 1'b1;
      #2 check_all_zero("reset");
      sample(3);
      reset = 1'b0;

      rel_q = '{20, 120, 220};
      campaign("tp3", 0, 3, 100, 10, 50, 0, 0);
      campaign("miss3", 0, 3, 100, 10, 50, 0, 0);
      rel_q = '{12, 25, 67};
      campaign("multi", 0, 1, 100, 10, 50, 0, 0);
      rel_q = '{10, 90};
      campaign("scan", 1, 2, 60, 5, 40, 500, 0);
      rel_q = '{-2, 10};
      campaign("short_p", 0, 4, 3, 0, 10, 0, 0);
      rel_q = '{20, 45, 140};
      campaign("empty_win", 0, 2, 80, 50, 40, 0, 0);
      rel_q = '{40, 60, 94};
      campaign("wide_close", 0, 2, 50, 30, 1000, 0, 0);
      rel_q = '{56};
      campaign("final_edge", 0, 2, 60, 0, 60, 0, 0);

      // Abort a campaign mid-listen of trial 2, then rerun cleanly.
      goto(cyc + 1);
      s = cyc;
      cfg_scan = 1'b0; num_trials = CNT_W'(3); trig_period = TIME_W'(100);
      win_open = TIME_W'(10); win_close = TIME_W'(50); start = 1'b1;
      for (int j = 0; j < 3; j++) wake_plan[s + 3 + 20 + j] = 1'b1;
      goto(s + 3);
      start = 1'b0;
      sample(s + 3 + 150);
      chk("abort_busy", busy, 1);
      chk("abort_tp", tp_cnt, 1);
      #1 reset = 1'b1;
      #1 check_all_zero("abort");
      @(negedge clki);
      reset = 1'b0;
      rel_q = '{20, 120, 220};
      campaign("after_rst", 0, 3, 100, 10, 50, 0, 1);

      rel_q = '{5};
      campaign("zero", 0, 0, 100, 10, 50, 0, 0);

      for (int r = 0; r < 4; r++) begin
         n  = $urandom_range(1, 5);
         p  = $urandom_range(20, 120);
         wo = $urandom_range(0, p);
         wc = $urandom_range(0, p + 20);
         cur = -2;
         while (cur < n * p + 10) begin
            if ($urandom_range(0, 2) == 0) rel_q.push_back(cur);
            cur += 6 + $urandom_range(0, 9);
         end
         campaign($sformatf("rnd%0d", r), 0, n, p, wo, wc, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
